// File: rtl/loader_defs.sv
// Shared definitions for the program loader: FSM state encoding and frame constants.
package loader_defs;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LEN_HI  = 4'd1,
    S_LEN_LO  = 4'd2,
    S_DATA_HI = 4'd3,
    S_DATA_LO = 4'd4,
    S_WRITE   = 4'd5,
    S_CHK     = 4'd6,
    S_HOLD    = 4'd7,
    S_RUN     = 4'd8,
    S_ERROR   = 4'd9
  } state_e;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/loader_rst_seq.sv
// CPU reset sequencer: holds reset for RST_HOLD cycles after a start pulse, then releases
// the CPU; an abort pulse reasserts reset immediately.
module loader_rst_seq #(
  parameter int unsigned RST_HOLD = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  input  logic i_abort,
  output logic o_done_c,
  output logic o_cpu_rst,
  output logic o_run
);

  localparam int unsigned CNT_W = $clog2(RST_HOLD + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_cpu_rst;
  logic             r_run;

  // Last hold cycle: the FSM moves to RUN on the same edge that releases reset.
  assign o_done_c  = (r_cnt == CNT_W'(1));
  assign o_cpu_rst = r_cpu_rst;
  assign o_run     = r_run;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_cpu_rst <= 1'b1;
      r_run     <= 1'b0;
    end else if (i_abort) begin
      r_cnt     <= '0;
      r_cpu_rst <= 1'b1;
      r_run     <= 1'b0;
    end else if (i_start) begin
      r_cnt     <= CNT_W'(RST_HOLD);
      r_cpu_rst <= 1'b1;
      r_run     <= 1'b0;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
      if (o_done_c) begin
        r_cpu_rst <= 1'b0;
        r_run     <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Boot loader: parses framed byte stream into 16-bit words, writes instruction RAM,
// verifies an XOR checksum and sequences the CPU out of reset.
module prog_loader
  import loader_defs::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned RST_HOLD = 4,
  parameter logic [7:0]  SYNC     = SYNC_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_rx_ready,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [15:0]       o_wr_data,
  output logic              o_cpu_rst,
  output logic              o_run,
  output logic              o_err
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

  state_e            r_state;
  state_e            w_next;
  logic [7:0]        r_len_hi;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_chk;
  logic [7:0]        r_hi;
  logic              r_rx_ready;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [15:0]       r_wr_data;
  logic              r_err;

  logic        w_accept;
  logic        w_is_sync;
  logic [15:0] w_len;
  logic        w_start;
  logic        w_abort;
  logic        w_hold_done;

  assign w_accept  = i_rx_valid & r_rx_ready;
  assign w_is_sync = (i_rx_data == SYNC);
  assign w_len     = {r_len_hi, i_rx_data};
  assign w_start   = (r_state == S_CHK) & w_accept & (i_rx_data == r_chk);
  assign w_abort   = (r_state == S_RUN) & w_accept & w_is_sync;

  assign o_rx_ready = r_rx_ready;
  assign o_wr_en    = r_wr_en;
  assign o_wr_addr  = r_wr_addr;
  assign o_wr_data  = r_wr_data;
  assign o_err      = r_err;

  loader_rst_seq #(
    .RST_HOLD (RST_HOLD)
  ) u_rst_seq (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (w_start),
    .i_abort   (w_abort),
    .o_done_c  (w_hold_done),
    .o_cpu_rst (o_cpu_rst),
    .o_run     (o_run)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_RUN, S_ERROR: if (w_accept && w_is_sync) w_next = S_LEN_HI;
      S_LEN_HI:  if (w_accept) w_next = S_LEN_LO;
      S_LEN_LO: begin
        if (w_accept) begin
          if ({1'b0, w_len} > DEPTH) w_next = S_ERROR;
          else if (w_len == 16'd0)   w_next = S_CHK;
          else                       w_next = S_DATA_HI;
        end
      end
      S_DATA_HI: if (w_accept) w_next = S_DATA_LO;
      S_DATA_LO: if (w_accept) w_next = S_WRITE;
      S_WRITE:   w_next = (r_cnt == CNT_W'(1)) ? S_CHK : S_DATA_HI;
      S_CHK:     if (w_accept) w_next = w_start ? S_HOLD : S_ERROR;
      S_HOLD:    if (w_hold_done) w_next = S_RUN;
      default:   w_next = S_IDLE;
    endcase
  end

  // Datapath and registered outputs; outputs are decoded from the next state so they
  // line up with the state they belong to from its first cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_len_hi   <= '0;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_chk      <= '0;
      r_hi       <= '0;
      r_rx_ready <= 1'b1;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_rx_ready <= (w_next != S_WRITE) && (w_next != S_HOLD);
      r_wr_en    <= (w_next == S_WRITE);
      r_err      <= (w_next == S_ERROR);
      case (r_state)
        S_IDLE, S_RUN, S_ERROR: begin
          if (w_accept && w_is_sync) begin
            r_len_hi <= '0;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_chk    <= '0;
          end
        end
        S_LEN_HI: if (w_accept) r_len_hi <= i_rx_data;
        // Truncation is safe: oversize lengths go to ERROR and never use the count.
        S_LEN_LO: if (w_accept) r_cnt <= CNT_W'(w_len);
        S_DATA_HI: begin
          if (w_accept) begin
            r_hi  <= i_rx_data;
            r_chk <= r_chk ^ i_rx_data;
          end
        end
        S_DATA_LO: begin
          if (w_accept) begin
            r_chk     <= r_chk ^ i_rx_data;
            r_wr_addr <= r_addr;
            r_wr_data <= {r_hi, i_rx_data};
          end
        end
        S_WRITE: begin
          r_addr <= r_addr + ADDR_W'(1);
          r_cnt  <= r_cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot/program controller for the CPU. Receives a framed byte stream over a valid/ready handshake and assembles big-endian 16-bit instruction words.
- Writes those words sequentially into the instruction RAM write port and verifies an XOR checksum.
- Sequences the CPU reset: the CPU is held in reset during load and released only after a verified image.
- Replaces hex preloading of the instruction memory with a synthesizable load path.

Parameters:
- ADDR_W, 8, instruction RAM address width; depth = 2**ADDR_W words.
- RST_HOLD, 4, cycles o_cpu_rst stays high after a good checksum before release (must be ≥1).
- SYNC, 8'hA5, frame start byte.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_rx_data  in  8  incoming byte.
- i_rx_valid  in  1  byte valid.
- o_rx_ready  out  1  byte accepted when i_rx_valid & o_rx_ready at a rising edge.
- o_wr_en  out  1  instruction RAM write strobe.
- o_wr_addr  out  ADDR_W  instruction RAM write address.
- o_wr_data  out  16  instruction word.
- o_cpu_rst  out  1  CPU reset (active-high, drives CPU i_rst).
- o_run  out  1  CPU released and running.
- o_err  out  1  last frame failed (checksum or length).

Behaviour:
- Interface: one clock, i_clk. i_rst is synchronous and active-high.
- Reset values: state=IDLE, o_cpu_rst=1, o_run=0, o_err=0, o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_rx_ready=1, length/count/checksum registers=0.
- Frame format: SYNC, LEN_HI, LEN_LO, then LEN words each sent high byte first, then one CHK byte. CHK = XOR of all data bytes (not SYNC or LEN).
- States and transitions:
  - IDLE: accepts and discards bytes until SYNC is received → LEN_HI. o_cpu_rst=1.
  - LEN_HI / LEN_LO: latch the 16-bit length. After LEN_LO:
    - LEN > 2**ADDR_W → ERROR.
    - LEN = 0 → CHK.
    - otherwise → DATA_HI.
    - Write address is cleared to 0 on SYNC.
  - DATA_HI: latch the high byte → DATA_LO.
  - DATA_LO: latch the low byte → WRITE.
  - WRITE: exactly one cycle.
    - o_wr_en=1, o_wr_addr=current address, o_wr_data=assembled word, o_rx_ready=0.
    - Next cycle: address+1, remaining count−1.
    - If remaining count was 1 → CHK, else → DATA_HI.
  - CHK: on accept, compare the received byte with the running XOR.
    - Equal → HOLD with the hold counter loaded to RST_HOLD.
    - Not equal → ERROR.
  - HOLD: o_rx_ready=0, o_cpu_rst=1. Counter decrements each cycle. At 0 → RUN.
  - RUN: o_cpu_rst=0, o_run=1, o_err=0, o_rx_ready=1. Non-SYNC bytes are discarded. SYNC → LEN_HI, with o_cpu_rst reasserted and o_run dropped the cycle after acceptance.
  - ERROR: o_err=1, o_cpu_rst=1, o_run=0. SYNC → LEN_HI and clears o_err. Other bytes are discarded.
- Register timing:
  - o_rx_ready is high in all states except WRITE and HOLD.
  - o_cpu_rst and o_run are registered and follow the state they belong to from the first cycle of that state.
  - o_wr_en is high only in WRITE.
- Running checksum: XOR is cleared on SYNC and updated on every accepted data byte.
- Length rules:
  - LEN = 2**ADDR_W is legal and fills the whole RAM.
  - The address must not wrap before CHK.
- Mid-frame events: a SYNC byte inside DATA/CHK is treated as data (no resync).
- Reset mid-load: i_rst at any cycle returns to the reset values. The partial RAM contents are left as-is, the CPU stays in reset, and the next frame must be complete.
- i_rx_valid low: no state change; the handshake may stall any number of cycles.

Decomposition:
- Shared package/header `loader_defs`: state encoding constants (IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHK, HOLD, RUN, ERROR) and the SYNC default.
- One natural sub-module: `loader_rst_seq`, the RST_HOLD down-counter generating o_cpu_rst/o_run from start/abort pulses.
- Everything else stays in the top FSM.

Test Plan:
- Good frame: stream A5 00 03 12 34 AB CD 00 01 41 with valid held high.
  - Required: writes (0,1234), (1,ABCD), (2,0001), each one-cycle o_wr_en.
  - o_cpu_rst falls exactly RST_HOLD cycles after CHK acceptance; o_run=1, o_err=0.
  - The CPU then executes the image: run the move test program and check WREG.
- Bad checksum: same frame with CHK=42.
  - Required: three writes occur, then o_err=1, o_cpu_rst stays 1, o_run=0.
  - A following good frame clears o_err and runs.
- Length limits:
  - ADDR_W=2 with LEN=5 → ERROR right after LEN_LO, no writes.
  - LEN=4 fills addresses 0..3 and runs.
  - LEN=0 with CHK=00 → RUN, no writes.
- Backpressure/stall: insert random i_rx_valid gaps and keep valid high during WRITE/HOLD.
  - Required: no byte lost or duplicated; o_rx_ready=0 in WRITE and HOLD; identical RAM contents.
- Reload while running: send A5 in RUN.
  - Required: o_cpu_rst=1 and o_run=0 the cycle after acceptance; the new image loads from address 0.
  - Junk bytes (00, FF) in IDLE/RUN are ignored.
- Reset mid-load: assert i_rst after the 2nd data byte.
  - Required: all outputs return to reset values next cycle; a subsequent full frame loads correctly.
